// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART RX bytes into register-file read/write requests.
// Frame: HEADER, OPCODE, ADDR, [D3 D2 D1 D0 on writes, MSB first], CHK.
// CHK is the XOR of every byte after HEADER. A request is issued with a one-cycle
// o_start pulse and held on o_addr/o_data_in/o_state_* until i_done arrives.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rx_data/valid   received byte and its one-cycle strobe
//   i_done            register file completion pulse
//   o_data_en         register file enable (0 in reset)
//   o_start           one-cycle request pulse
//   o_state_r/w/fail  request type flags, held until retired
//   o_addr, o_data_in request address and write data
//   o_busy            frame in progress or request outstanding
//   o_err_cnt         saturating count of failed frames and DONE timeouts
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_done,
  output logic        o_data_en,
  output logic        o_start,
  output logic        o_state_r,
  output logic        o_state_w,
  output logic        o_state_fail,
  output logic [7:0]  o_addr,
  output logic [31:0] o_data_in,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR, S_OP, S_ADDR, S_DATA, S_CHK, S_ISSUE, S_WAIT
  } state_t;

  state_t          r_state, w_state;
  logic [7:0]      r_chk, w_chk;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt;
  logic [1:0]      r_byte_cnt, w_byte_cnt;
  logic            r_is_write, w_is_write;
  logic [7:0]      r_addr, w_addr;
  logic [31:0]     r_data, w_data;
  logic            r_start, w_start;
  logic            r_state_r, w_state_r;
  logic            r_state_w, w_state_w;
  logic            r_state_fail, w_state_fail;
  logic            r_busy, w_busy;
  logic [7:0]      r_err_cnt, w_err_cnt;
  logic            r_data_en;
  logic            w_timeout, w_issue, w_fail, w_err_inc;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_HDR;
      r_chk        <= '0;
      r_to_cnt     <= '0;
      r_byte_cnt   <= '0;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_start      <= 1'b0;
      r_state_r    <= 1'b0;
      r_state_w    <= 1'b0;
      r_state_fail <= 1'b0;
      r_busy       <= 1'b0;
      r_err_cnt    <= '0;
      r_data_en    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_chk        <= w_chk;
      r_to_cnt     <= w_to_cnt;
      r_byte_cnt   <= w_byte_cnt;
      r_is_write   <= w_is_write;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_start      <= w_start;
      r_state_r    <= w_state_r;
      r_state_w    <= w_state_w;
      r_state_fail <= w_state_fail;
      r_busy       <= w_busy;
      r_err_cnt    <= w_err_cnt;
      r_data_en    <= 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_chk        = r_chk;
    w_to_cnt     = r_to_cnt;
    w_byte_cnt   = r_byte_cnt;
    w_is_write   = r_is_write;
    w_addr       = r_addr;
    w_data       = r_data;
    w_start      = 1'b0;
    w_state_r    = r_state_r;
    w_state_w    = r_state_w;
    w_state_fail = r_state_fail;
    w_err_cnt    = r_err_cnt;
    w_issue      = 1'b0;
    w_fail       = 1'b0;
    w_err_inc    = 1'b0;
    w_timeout    = (r_to_cnt == TO_LAST);

    case (r_state)
      S_HDR: begin
        w_to_cnt = '0;
        if (i_rx_valid && (i_rx_data == HEADER)) begin
          w_state = S_OP;
          w_chk   = '0;
        end
      end

      S_OP, S_ADDR, S_DATA, S_CHK: begin
        // An arriving byte takes priority over an expiring inter-byte timeout
        if (i_rx_valid) begin
          w_to_cnt = '0;
          w_chk    = r_chk ^ i_rx_data;
          case (r_state)
            S_OP: begin
              if ((i_rx_data == OP_READ) || (i_rx_data == OP_WRITE)) begin
                w_is_write = (i_rx_data == OP_WRITE);
                w_state    = S_ADDR;
              end else begin
                w_issue = 1'b1;
                w_fail  = 1'b1;
                w_addr  = '0;
                w_data  = '0;
              end
            end
            S_ADDR: begin
              w_addr     = i_rx_data;
              w_byte_cnt = '0;
              w_state    = r_is_write ? S_DATA : S_CHK;
            end
            S_DATA: begin
              w_data     = {r_data[23:0], i_rx_data};
              w_byte_cnt = r_byte_cnt + 2'(1);
              if (r_byte_cnt == 2'd3) begin
                w_state = S_CHK;
              end
            end
            default: begin
              w_issue = 1'b1;
              w_fail  = (i_rx_data != r_chk);
            end
          endcase
        end else if (w_timeout) begin
          w_issue = 1'b1;
          w_fail  = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + TO_W'(1);
        end
      end

      S_ISSUE: begin
        w_state  = S_WAIT;
        w_to_cnt = '0;
      end

      S_WAIT: begin
        // Incoming bytes are ignored until the request retires
        if (i_done) begin
          w_state      = S_HDR;
          w_state_r    = 1'b0;
          w_state_w    = 1'b0;
          w_state_fail = 1'b0;
          w_to_cnt     = '0;
        end else if (w_timeout) begin
          w_state      = S_HDR;
          w_state_r    = 1'b0;
          w_state_w    = 1'b0;
          w_state_fail = 1'b0;
          w_to_cnt     = '0;
          w_err_inc    = 1'b1;
        end else begin
          w_to_cnt = r_to_cnt + TO_W'(1);
        end
      end

      default: begin
        w_state = S_HDR;
      end
    endcase

    // Launch a request: exactly one type flag set alongside the start pulse
    if (w_issue) begin
      w_state      = S_ISSUE;
      w_start      = 1'b1;
      w_state_fail = w_fail;
      w_state_w    = ~w_fail & r_is_write;
      w_state_r    = ~w_fail & ~r_is_write;
      w_to_cnt     = '0;
      w_err_inc    = w_fail;
    end

    if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      w_err_cnt = r_err_cnt + 8'(1);
    end

    w_busy = (w_state != S_HDR);
  end

  assign o_data_en    = r_data_en;
  assign o_start      = r_start;
  assign o_state_r    = r_state_r;
  assign o_state_w    = r_state_w;
  assign o_state_fail = r_state_fail;
  assign o_addr       = r_addr;
  assign o_data_in    = r_data;
  assign o_busy       = r_busy;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with a shortened timeout.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        done;
  logic        o_data_en, o_start, o_state_r, o_state_w, o_state_fail, o_busy;
  logic [7:0]  o_addr, o_err_cnt;
  logic [31:0] o_data_in;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .TO_W(7)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_done(done),
    .o_data_en(o_data_en),
    .o_start(o_start),
    .o_state_r(o_state_r),
    .o_state_w(o_state_w),
    .o_state_fail(o_state_fail),
    .o_addr(o_addr),
    .o_data_in(o_data_in),
    .o_busy(o_busy),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic        f;
    logic        chk_ad;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_start = 0;
  logic [7:0] exp_err = 8'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic w, input logic f, input logic ca,
                      input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.r = r; e.w = w; e.f = f; e.chk_ad = ca; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Every start pulse is matched against the oldest expected request
  always @(negedge clk) begin
    if (!rst && o_start) begin
      exp_t e;
      n_start++;
      if (sb.size() == 0) begin
        check("unexpected_start", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("start_r", 32'(o_state_r), 32'(e.r));
        check("start_w", 32'(o_state_w), 32'(e.w));
        check("start_fail", 32'(o_state_fail), 32'(e.f));
        if (e.chk_ad) begin
          check("start_addr", 32'(o_addr), 32'(e.addr));
          check("start_data", o_data_in, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_start(input string tag, input int target);
    for (int i = 0; i < 200; i++) begin
      if (n_start >= target) break;
      @(negedge clk);
    end
    check(tag, 32'(n_start), 32'(target));
  endtask

  // Check the held request, pulse DONE, check it retires
  task automatic retire(input logic r, input logic w, input logic f, input logic ca,
                        input logic [7:0] a);
    @(negedge clk);
    check("start_one_cycle", 32'(o_start), 32'(0));
    check("busy_held", 32'(o_busy), 32'(1));
    repeat (3) @(negedge clk);
    check("hold_flags", 32'({o_state_r, o_state_w, o_state_fail}), 32'({r, w, f}));
    if (ca) check("hold_addr", 32'(o_addr), 32'(a));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("retired_flags", 32'({o_state_r, o_state_w, o_state_fail}), 32'(0));
    check("retired_busy", 32'(o_busy), 32'(0));
    check("err_cnt", 32'(o_err_cnt), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    int n0;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({o_data_en, o_start, o_state_r, o_state_w, o_state_fail, o_busy}), 32'(0));
    check("rst_addr_err", 32'({o_addr, o_err_cnt}), 32'(0));
    check("rst_data", o_data_in, 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("data_en_after_rst", 32'(o_data_en), 32'(1));

    // Write frame
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    fr = '{8'hA5, 8'h57, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h65};
    send_bytes(fr);
    check("write_start_latency", 32'(o_start), 32'(1));
    retire(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    check("write_data_held", o_data_in, 32'hDEADBEEF);

    // Read frame
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    fr = '{8'hA5, 8'h52, 8'h10, 8'h42};
    send_bytes(fr);
    check("read_start_latency", 32'(o_start), 32'(1));
    retire(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);

    // Bad checksum
    exp_err = 8'd1;
    push(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    fr = '{8'hA5, 8'h52, 8'h10, 8'h00};
    send_bytes(fr);
    check("badchk_start_latency", 32'(o_start), 32'(1));
    retire(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Bad opcode clears address and data
    exp_err = 8'd2;
    push(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0);
    fr = '{8'hA5, 8'h33};
    send_bytes(fr);
    check("badop_start_latency", 32'(o_start), 32'(1));
    retire(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

    // Garbage before a read, bytes during the wait dropped
    n0 = n_start;
    fr = '{8'h00, 8'hFF, 8'h12};
    send_bytes(fr);
    check("garbage_no_start", 32'(n_start), 32'(n0));
    check("garbage_not_busy", 32'(o_busy), 32'(0));
    push(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 32'h0);
    fr = '{8'hA5, 8'h52, 8'h10, 8'h42};
    send_bytes(fr);
    check("garbage_read_latency", 32'(o_start), 32'(1));
    fr = '{8'hA5, 8'h52, 8'h20, 8'h72};
    send_bytes(fr);
    retire(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    repeat (5) @(negedge clk);
    check("dropped_bytes_one_start", 32'(n_start), 32'(n0 + 1));

    // Inter-byte timeout, then DONE timeout
    n0 = n_start;
    exp_err = 8'd3;
    push(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    fr = '{8'hA5, 8'h57, 8'h10};
    send_bytes(fr);
    wait_start("byte_timeout_start", n0 + 1);
    check("byte_timeout_err", 32'(o_err_cnt), 32'(exp_err));
    exp_err = 8'd4;
    for (int i = 0; i < 200; i++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    check("done_timeout_idle", 32'(o_busy), 32'(0));
    check("done_timeout_flags", 32'({o_state_r, o_state_w, o_state_fail}), 32'(0));
    check("done_timeout_err", 32'(o_err_cnt), 32'(exp_err));
    check("done_timeout_no_start", 32'(n_start), 32'(n0 + 1));

    // Reset mid-frame aborts silently
    n0 = n_start;
    fr = '{8'hA5, 8'h57};
    send_bytes(fr);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_outputs", 32'({o_data_en, o_start, o_state_r, o_state_w, o_state_fail, o_busy}), 32'(0));
    check("midrst_err", 32'(o_err_cnt), 32'(0));
    exp_err = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data_en", 32'(o_data_en), 32'(1));
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 32'h01020304);
    fr = '{8'hA5, 8'h57, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 8'h71};
    send_bytes(fr);
    check("postrst_write_latency", 32'(o_start), 32'(1));
    retire(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    check("postrst_one_start", 32'(n_start), 32'(n0 + 1));

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
